// File: rtl/branch_predictor.sv
// Branch target buffer with 2-bit saturating direction counters.
//
// Fetch presents lookup_pc and gets a zero-latency prediction
// (pred_hit, pred_taken, pred_next) from the registered table state.
// The resolve stage presents upd_* with the actual outcome. The block
// trains the table and, one cycle later, raises a mispredict/redirect
// pair so the core can flush its front end.
//
// Ports:
//   clk, rst_n      clock, synchronous active-low reset
//   lookup_pc       fetch PC
//   pred_hit        valid entry with matching tag
//   pred_taken      pred_hit & counter msb
//   pred_next       predicted next PC
//   upd_valid       resolved branch present this cycle
//   upd_pc          PC of the resolved branch
//   upd_taken       actual direction
//   upd_target      actual taken target
//   upd_pred_next   prediction that was made for this branch
//   mispredict      registered, high for one cycle after a wrong prediction
//   redirect_pc     registered correct next PC, valid with mispredict
//   stat_branches   saturating resolved-branch count
//   stat_mispred    saturating misprediction count
module branch_predictor #(
    parameter int unsigned ADDR_W    = 16,
    parameter int unsigned ENTRIES   = 16,
    parameter int unsigned PC_ALIGN  = 2,
    parameter logic [1:0]  ALLOC_CTR = 2'b10,
    parameter int unsigned STAT_W    = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [ADDR_W-1:0] lookup_pc,
    output logic              pred_hit,
    output logic              pred_taken,
    output logic [ADDR_W-1:0] pred_next,
    input  logic              upd_valid,
    input  logic [ADDR_W-1:0] upd_pc,
    input  logic              upd_taken,
    input  logic [ADDR_W-1:0] upd_target,
    input  logic [ADDR_W-1:0] upd_pred_next,
    output logic              mispredict,
    output logic [ADDR_W-1:0] redirect_pc,
    output logic [STAT_W-1:0] stat_branches,
    output logic [STAT_W-1:0] stat_mispred
);

    localparam int unsigned IDX_W = $clog2(ENTRIES);
    localparam int unsigned TAG_W = ADDR_W - PC_ALIGN - IDX_W;
    localparam logic [ADDR_W-1:0] PC_STEP = ADDR_W'(1) << PC_ALIGN;

    // Table state. Tags and targets carry no reset; valid guards them.
    logic              valid_q  [ENTRIES];
    logic [1:0]        ctr_q    [ENTRIES];
    logic [TAG_W-1:0]  tag_q    [ENTRIES];
    logic [ADDR_W-1:0] target_q [ENTRIES];

    logic              mispredict_q;
    logic [ADDR_W-1:0] redirect_pc_q;
    logic [STAT_W-1:0] stat_branches_q;
    logic [STAT_W-1:0] stat_mispred_q;

    // Lookup side
    logic [IDX_W-1:0] l_idx;
    logic [TAG_W-1:0] l_tag;
    logic             l_hit;

    always_comb begin
        l_idx      = lookup_pc[PC_ALIGN +: IDX_W];
        l_tag      = lookup_pc[ADDR_W-1 -: TAG_W];
        l_hit      = valid_q[l_idx] && (tag_q[l_idx] == l_tag);
        pred_hit   = l_hit;
        pred_taken = l_hit && ctr_q[l_idx][1];
        pred_next  = (l_hit && ctr_q[l_idx][1]) ? target_q[l_idx] : lookup_pc + PC_STEP;
    end

    // Update side
    logic [IDX_W-1:0]  u_idx;
    logic [TAG_W-1:0]  u_tag;
    logic              u_hit;
    logic [ADDR_W-1:0] actual_next;
    logic              u_mispred;

    always_comb begin
        u_idx       = upd_pc[PC_ALIGN +: IDX_W];
        u_tag       = upd_pc[ADDR_W-1 -: TAG_W];
        u_hit       = valid_q[u_idx] && (tag_q[u_idx] == u_tag);
        actual_next = upd_taken ? upd_target : upd_pc + PC_STEP;
        u_mispred   = (actual_next != upd_pred_next);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < ENTRIES; i++) begin
                valid_q[i] <= 1'b0;
                ctr_q[i]   <= 2'b00;
            end
            mispredict_q    <= 1'b0;
            redirect_pc_q   <= '0;
            stat_branches_q <= '0;
            stat_mispred_q  <= '0;
        end else begin
            mispredict_q <= 1'b0;
            // Everything below is gated by upd_valid so X on idle upd_* is harmless.
            if (upd_valid) begin
                mispredict_q  <= u_mispred;
                redirect_pc_q <= actual_next;
                if (stat_branches_q != '1) begin
                    stat_branches_q <= stat_branches_q + STAT_W'(1);
                end
                if (u_mispred && (stat_mispred_q != '1)) begin
                    stat_mispred_q <= stat_mispred_q + STAT_W'(1);
                end

                if (u_hit) begin
                    if (upd_taken) begin
                        if (ctr_q[u_idx] != 2'b11) begin
                            ctr_q[u_idx] <= ctr_q[u_idx] + 2'b01;
                        end
                        target_q[u_idx] <= upd_target;
                    end else if (ctr_q[u_idx] != 2'b00) begin
                        ctr_q[u_idx] <= ctr_q[u_idx] - 2'b01;
                    end
                end else if (upd_taken) begin
                    // Direct-mapped: a taken miss evicts whatever aliases here.
                    valid_q[u_idx]  <= 1'b1;
                    tag_q[u_idx]    <= u_tag;
                    target_q[u_idx] <= upd_target;
                    ctr_q[u_idx]    <= ALLOC_CTR;
                end
            end
        end
    end

    assign mispredict    = mispredict_q;
    assign redirect_pc   = redirect_pc_q;
    assign stat_branches = stat_branches_q;
    assign stat_mispred  = stat_mispred_q;

endmodule

// File: tb/tb_branch_predictor.sv
module tb_branch_predictor;

    localparam int unsigned SW = 4;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [15:0]   lookup_pc;
    logic          pred_hit;
    logic          pred_taken;
    logic [15:0]   pred_next;
    logic          upd_valid;
    logic [15:0]   upd_pc;
    logic          upd_taken;
    logic [15:0]   upd_target;
    logic [15:0]   upd_pred_next;
    logic          mispredict;
    logic [15:0]   redirect_pc;
    logic [SW-1:0] stat_branches;
    logic [SW-1:0] stat_mispred;

    int errors = 0;
    int checks = 0;

    branch_predictor #(
        .ADDR_W   (16),
        .ENTRIES  (16),
        .PC_ALIGN (2),
        .ALLOC_CTR(2'b10),
        .STAT_W   (SW)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .lookup_pc    (lookup_pc),
        .pred_hit     (pred_hit),
        .pred_taken   (pred_taken),
        .pred_next    (pred_next),
        .upd_valid    (upd_valid),
        .upd_pc       (upd_pc),
        .upd_taken    (upd_taken),
        .upd_target   (upd_target),
        .upd_pred_next(upd_pred_next),
        .mispredict   (mispredict),
        .redirect_pc  (redirect_pc),
        .stat_branches(stat_branches),
        .stat_mispred (stat_mispred)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic upd(input logic [15:0] pc, input logic tk, input logic [15:0] tgt,
                       input logic [15:0] pn);
        upd_valid     = 1'b1;
        upd_pc        = pc;
        upd_taken     = tk;
        upd_target    = tgt;
        upd_pred_next = pn;
    endtask

    task automatic look(input logic [15:0] pc, input logic hit, input logic tk,
                        input logic [15:0] nxt, input string tag);
        lookup_pc = pc;
        #1;
        chk({tag, ".hit"}, 32'(pred_hit), 32'(hit));
        chk({tag, ".taken"}, 32'(pred_taken), 32'(tk));
        chk({tag, ".next"}, 32'(pred_next), 32'(nxt));
    endtask

    logic [15:0] nt_pn [4] = '{16'h0100, 16'h0044, 16'h0044, 16'h0044};
    logic        nt_mp [4] = '{1'b1, 1'b0, 1'b0, 1'b0};

    initial begin
        rst_n = 1'b0;
        lookup_pc = 16'h0000;
        upd_valid = 1'b0;
        upd_pc = '0;
        upd_taken = 1'b0;
        upd_target = '0;
        upd_pred_next = '0;
        tick();
        tick();
        rst_n = 1'b1;

        // Reset state
        look(16'h0040, 1'b0, 1'b0, 16'h0044, "rst_look");
        chk("rst_mispredict", 32'(mispredict), 32'd0);
        chk("rst_redirect", 32'(redirect_pc), 32'h0);
        chk("rst_branches", 32'(stat_branches), 32'd0);
        chk("rst_mispred", 32'(stat_mispred), 32'd0);

        // Allocate on taken miss
        upd(16'h0040, 1'b1, 16'h0100, 16'h0044);
        tick();
        upd_valid = 1'b0;
        chk("alloc_mispredict", 32'(mispredict), 32'd1);
        chk("alloc_redirect", 32'(redirect_pc), 32'h0100);
        chk("alloc_branches", 32'(stat_branches), 32'd1);
        chk("alloc_mispred", 32'(stat_mispred), 32'd1);
        look(16'h0040, 1'b1, 1'b1, 16'h0100, "alloc_look");

        // Four consecutive not-taken updates: ctr 2->1->0->0
        for (int k = 0; k < 4; k++) begin
            lookup_pc = 16'h0040;
            upd(16'h0040, 1'b0, 16'h0100, nt_pn[k]);
            #1;
            chk("nt_pred_next", 32'(pred_next), 32'(nt_pn[k]));
            tick();
            chk("nt_mispredict", 32'(mispredict), 32'(nt_mp[k]));
            chk("nt_redirect", 32'(redirect_pc), 32'h0044);
        end
        upd_valid = 1'b0;
        look(16'h0040, 1'b1, 1'b0, 16'h0044, "nt_look");
        chk("nt_branches", 32'(stat_branches), 32'd5);
        chk("nt_mispred", 32'(stat_mispred), 32'd2);
        tick();
        chk("idle_mispredict", 32'(mispredict), 32'd0);
        chk("idle_redirect_hold", 32'(redirect_pc), 32'h0044);

        // Alias: 0x0080 shares index 0 with 0x0040
        upd(16'h0080, 1'b1, 16'h0200, 16'h0084);
        look(16'h0080, 1'b0, 1'b0, 16'h0084, "alias_pre");
        tick();
        upd_valid = 1'b0;
        chk("alias_mispredict", 32'(mispredict), 32'd1);
        chk("alias_redirect", 32'(redirect_pc), 32'h0200);
        look(16'h0040, 1'b0, 1'b0, 16'h0044, "alias_old");
        look(16'h0080, 1'b1, 1'b1, 16'h0200, "alias_new");

        // Same-cycle lookup/update: old contents until next cycle
        upd(16'h0080, 1'b1, 16'h0300, 16'h0200);
        look(16'h0080, 1'b1, 1'b1, 16'h0200, "same_pre");
        tick();
        upd_valid = 1'b0;
        look(16'h0080, 1'b1, 1'b1, 16'h0300, "same_post");
        chk("same_branches", 32'(stat_branches), 32'd7);
        chk("same_mispred", 32'(stat_mispred), 32'd4);

        // X on upd_* while idle must not disturb state
        upd_pc = 'x;
        upd_taken = 1'bx;
        upd_target = 'x;
        upd_pred_next = 'x;
        tick();
        tick();
        look(16'h0080, 1'b1, 1'b1, 16'h0300, "idle_x");
        chk("idle_x_branches", 32'(stat_branches), 32'd7);
        chk("idle_x_mispredict", 32'(mispredict), 32'd0);

        // Saturation of both statistics counters at 4'hF
        for (int k = 0; k < 20; k++) begin
            upd(16'h0080, 1'b1, 16'h0300, 16'h0300);
            tick();
        end
        chk("sat_branches", 32'(stat_branches), 32'hF);
        chk("sat_mispred_hold", 32'(stat_mispred), 32'd4);
        for (int k = 0; k < 12; k++) begin
            upd(16'h0080, 1'b1, 16'h0300, 16'h0000);
            tick();
        end
        chk("sat_mispred", 32'(stat_mispred), 32'hF);
        chk("sat_branches_hold", 32'(stat_branches), 32'hF);

        // Reset mid-stream with a pending mispredict and a live update
        upd(16'h0040, 1'b1, 16'h0500, 16'h0044);
        tick();
        chk("pre_rst_mispredict", 32'(mispredict), 32'd1);
        chk("pre_rst_redirect", 32'(redirect_pc), 32'h0500);
        upd(16'h0040, 1'b1, 16'h0600, 16'h0044);
        rst_n = 1'b0;
        tick();
        chk("mid_rst_mispredict", 32'(mispredict), 32'd0);
        chk("mid_rst_redirect", 32'(redirect_pc), 32'h0);
        chk("mid_rst_branches", 32'(stat_branches), 32'd0);
        chk("mid_rst_mispred", 32'(stat_mispred), 32'd0);
        rst_n = 1'b1;
        upd_valid = 1'b0;
        tick();
        look(16'h0040, 1'b0, 1'b0, 16'h0044, "post_rst_0040");
        look(16'h0080, 1'b0, 1'b0, 16'h0084, "post_rst_0080");
        chk("post_rst_branches", 32'(stat_branches), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/branch_predictor.md
Name: branch_predictor

Overview:
- Parametrised branch target buffer (BTB) with 2-bit saturating direction counters for the pipelined CPU.
- Fetch looks up the current PC combinationally and gets a predicted next PC.
- The resolve stage (EX/MEM) returns the actual outcome. The block trains the table and raises a registered mispredict/redirect so the core can flush IF/ID and ID/EX.
- Replaces late, always-not-taken branch resolution with early prediction.

Parameters:
ADDR_W, 16, PC/target width in bits
ENTRIES, 16, BTB entries; power of two, >=2; IDX_W = log2(ENTRIES)
PC_ALIGN, 2, low PC bits ignored; sequential PC = pc + (1<<PC_ALIGN)
ALLOC_CTR, 2, counter value written on allocation (2'b10 = weakly taken)
STAT_W, 16, width of statistics counters

Ports:
clk  in  1  global clock
rst_n  in  1  reset, synchronous, active-low
lookup_pc  in  ADDR_W  fetch PC
pred_hit  out  1  valid entry with matching tag
pred_taken  out  1  pred_hit & counter[1]
pred_next  out  ADDR_W  predicted next PC
upd_valid  in  1  resolved branch present this cycle
upd_pc  in  ADDR_W  PC of resolved branch
upd_taken  in  1  actual direction
upd_target  in  ADDR_W  actual taken target
upd_pred_next  in  ADDR_W  pred_next carried down the pipe for this branch
mispredict  out  1  registered; high 1 cycle after a wrong prediction
redirect_pc  out  ADDR_W  registered correct next PC; valid when mispredict=1
stat_branches  out  STAT_W  resolved-branch count, saturating
stat_mispred  out  STAT_W  misprediction count, saturating

Behaviour:
- Index = pc[PC_ALIGN +: IDX_W]; tag = pc[ADDR_W-1 : PC_ALIGN+IDX_W]. Each entry holds valid, tag, target[ADDR_W], ctr[2].
- Lookup is purely combinational from registered table state, zero latency.
  - pred_next = (hit & ctr[1]) ? target : lookup_pc + (1<<PC_ALIGN).
  - Addition wraps modulo 2^ADDR_W.
- actual_next = upd_taken ? upd_target : upd_pc + (1<<PC_ALIGN), wrapping.
- At posedge with upd_valid=1:
  - mispredict <= (actual_next != upd_pred_next).
  - redirect_pc <= actual_next.
  - stat_branches +1, saturating at all-ones.
  - stat_mispred +1 on mispredict, saturating at all-ones.
- Cycle with upd_valid=0: mispredict <= 0; redirect_pc holds its value.
- Table training on upd_valid, at upd_pc's index:
  - Hit, taken: ctr = min(ctr+1, 3); target <= upd_target.
  - Hit, not taken: ctr = max(ctr-1, 0); target unchanged; entry stays valid.
  - Miss, taken: allocate, overwriting any occupant: valid=1, tag, target=upd_target, ctr=ALLOC_CTR.
  - Miss, not taken: no table change.
- Lookup and update to the same index in the same cycle: lookup returns pre-update contents; the update is visible from the next cycle. No bypass.
- Aliasing (same index, different tag) is a miss. Replacement is direct-mapped only.
- Reset (rst_n=0 at posedge):
  - Clears all valid bits and ctr to 0, mispredict=0, redirect_pc=0, both stat counters=0.
  - Tags and targets need not be cleared.
  - An upd_valid coinciding with reset is ignored.
  - Outputs after reset: pred_hit=0, pred_taken=0, pred_next=lookup_pc+(1<<PC_ALIGN).
- Reset mid-operation discards all learned state and any pending mispredict. No partial updates.
- Duplicate updates for the same PC in consecutive cycles are each applied in order.
- X on upd_* while upd_valid=0 must not affect state.

Test Plan:
- Reset then lookup_pc=16'h0040 -> pred_hit=0, pred_taken=0, pred_next=16'h0044; stats=0, mispredict=0.
- Update upd_pc=16'h0040, taken, target=16'h0100, upd_pred_next=16'h0044 -> next cycle mispredict=1, redirect_pc=16'h0100, stat_mispred=1. Then lookup 16'h0040 -> hit, taken, pred_next=16'h0100.
- Same branch: four not-taken updates after allocation -> ctr 2→1→0→0. Lookup gives pred_taken=0, pred_next=16'h0044, pred_hit=1. Mispredict asserted on the first not-taken update only, provided upd_pred_next matches the lookup.
- Alias: allocate 16'h0040, then taken update at 16'h0080 (same index with ENTRIES=16) -> lookup 16'h0040 misses; 16'h0080 hits with its new target.
- Lookup and update same index same cycle -> lookup shows old entry; changed value appears the following cycle.
- Force stat_branches to all-ones (or STAT_W=4 build, 20 updates) -> holds 4'hF, no wrap. Assert rst_n=0 mid-stream with upd_valid=1 -> all counters 0, table empty, mispredict=0.
